// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel readout controller.
//   state_t : frame sequencer states
//   EXP_W   : width of the exposure-length input
package pixel_pkg;

    localparam int EXP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ
    } state_t;

endpackage

// File: rtl/pixel_readout_ctrl_if.sv
// Frame request / pixel strobe bundle of the pixel readout controller.
//   master : frame requester (drives start, abort, continuous, exp_cycles)
//   slave  : controller (drives erase, expose, convert, read, count, busy, frame_done)
interface pixel_readout_ctrl_if #(
    parameter int N_ROWS = 4,
    parameter int DATA_W = 8
);
    import pixel_pkg::*;

    logic              start;
    logic              abort;
    logic              continuous;
    logic [EXP_W-1:0]  exp_cycles;
    logic              erase;
    logic              expose;
    logic              convert;
    logic [N_ROWS-1:0] read;
    logic [DATA_W-1:0] count;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, abort, continuous, exp_cycles,
        input  erase, expose, convert, read, count, busy, frame_done
    );

    modport slave (
        input  start, abort, continuous, exp_cycles,
        output erase, expose, convert, read, count, busy, frame_done
    );
endinterface

// File: rtl/pixel_ramp_counter.sv
// ADC ramp counter. Counts 0,1,2,... on each cycle en is high; clears to 0
// on any cycle en is low. count is registered.
// Build option: PIXEL_READOUT_GRAY_EN drives count Gray-encoded (b ^ (b >> 1)).
//   clk   : clock
//   reset : synchronous active-high reset
//   en    : advance the ramp (low clears it)
//   count : ramp value
module pixel_ramp_counter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [DATA_W-1:0] count
);
    logic [DATA_W-1:0] bin;
    logic [DATA_W-1:0] bin_n;

    always_comb bin_n = bin + DATA_W'(1);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            bin   <= '0;
            count <= '0;
        end else begin
            bin   <= bin_n;
`ifdef PIXEL_READOUT_GRAY_EN
            count <= bin_n ^ (bin_n >> 1);
`else
            count <= bin_n;
`endif
        end
    end
endmodule

// File: rtl/pixel_readout_ctrl.sv
// Pixel frame sequencer: ERASE -> EXPOSE -> CONVERT (ADC ramp) -> READ rows,
// then IDLE, or straight back to ERASE in continuous mode. All outputs registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of pixel_readout_ctrl_if (requests in, strobes out)
// Build option: PIXEL_READOUT_GRAY_EN selects Gray-coded count (see pixel_ramp_counter).
module pixel_readout_ctrl
    import pixel_pkg::*;
#(
    parameter int N_ROWS    = 4,
    parameter int DATA_W    = 8,
    parameter int ERASE_CYC = 5,
    parameter int READ_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_readout_ctrl_if.slave   bus
);
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [31:0] ERASE_LAST = 32'(ERASE_CYC - 1);
    localparam logic [31:0] CONV_LAST  = 32'((64'd1 << DATA_W) - 64'd1);
    localparam logic [31:0] READ_LAST  = 32'(READ_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    state_t            state, state_n;
    logic [31:0]       cnt, cnt_n;
    logic [ROW_W-1:0]  row, row_n;
    logic [EXP_W-1:0]  exp_q;
    logic [EXP_W-1:0]  exp_eff;
    logic              latch, done_n, ramp_en;
    logic [N_ROWS-1:0] read_n;

    logic              erase_q, expose_q, convert_q, busy_q, done_q;
    logic [N_ROWS-1:0] read_q;

    // An exposure length of 0 is run as a single cycle.
    always_comb exp_eff = (exp_q == '0) ? EXP_W'(1) : exp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
            exp_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
            if (latch)
                exp_q <= bus.exp_cycles;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        latch   = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ERASE;
                    cnt_n   = '0;
                    row_n   = '0;
                    latch   = 1'b1;
                end
            end
            ERASE: begin
                if (cnt == ERASE_LAST) begin
                    state_n = EXPOSE;
                    cnt_n   = '0;
                end else
                    cnt_n = cnt + 32'd1;
            end
            EXPOSE: begin
                if (cnt == 32'(exp_eff) - 32'd1) begin
                    state_n = CONVERT;
                    cnt_n   = '0;
                end else
                    cnt_n = cnt + 32'd1;
            end
            CONVERT: begin
                if (cnt == CONV_LAST) begin
                    state_n = READ;
                    cnt_n   = '0;
                    row_n   = '0;
                end else
                    cnt_n = cnt + 32'd1;
            end
            READ: begin
                if (cnt == READ_LAST) begin
                    cnt_n = '0;
                    if (row == ROW_LAST) begin
                        done_n = 1'b1;
                        row_n  = '0;
                        if (bus.continuous) begin
                            state_n = ERASE;
                            latch   = 1'b1;
                        end else
                            state_n = IDLE;
                    end else
                        row_n = row + ROW_W'(1);
                end else
                    cnt_n = cnt + 32'd1;
            end
            default: state_n = IDLE;
        endcase
        if (bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            row_n   = '0;
            latch   = 1'b0;
            done_n  = 1'b0;
        end
    end

    // Ramp runs only while CONVERT continues into the next cycle, so the
    // counter reads 0 on entry and is already cleared on exit or abort.
    always_comb ramp_en = (state == CONVERT) && (state_n == CONVERT);

    always_comb begin
        read_n = '0;
        if (state_n == READ)
            read_n[row_n] = 1'b1;
    end

    // Strobes are decoded from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            erase_q   <= (state_n == ERASE);
            expose_q  <= (state_n == EXPOSE);
            convert_q <= (state_n == CONVERT);
            read_q    <= read_n;
            busy_q    <= (state_n != IDLE);
            done_q    <= done_n;
        end
    end

    pixel_ramp_counter #(.DATA_W(DATA_W)) u_ramp (
        .clk   (clk),
        .reset (reset),
        .en    (ramp_en),
        .count (bus.count)
    );

    assign bus.erase      = erase_q;
    assign bus.expose     = expose_q;
    assign bus.convert    = convert_q;
    assign bus.read       = read_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule
